// File: rtl/fp_calc_pkg.sv
// fp_calc_pkg: shared states, display character codes and ALU opcodes for the Basys 3 FP calculator.
package fp_calc_pkg;
    typedef enum logic [3:0] {OFF, LDAH, LDAL, LDBH, LDBL, CONF, COMPUTE, RESULT, IDLE} state_t;
    localparam logic [4:0] CHAR_0 = 5'h00;
    localparam logic [4:0] CHAR_A = 5'h0A;
    localparam logic [4:0] CHAR_B = 5'h0B;
    localparam logic [4:0] CHAR_C = 5'h0C;
    localparam logic [4:0] CHAR_D = 5'h0D;
    localparam logic [4:0] CHAR_F = 5'h0F;
    localparam logic [4:0] CHAR_n = 5'h10;
    localparam logic [4:0] CHAR_r = 5'h11;
    localparam logic [4:0] CHAR_L = 5'h12;
    localparam logic [4:0] CHAR_H = 5'h13;
    localparam logic [4:0] BLANK  = 5'h14;
    localparam logic [4:0] CHAR_I = 5'h15;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
endpackage

// File: rtl/fp_alu.sv
// fp_alu: multi-cycle add/sub/mul/div in single or half precision (truncating, denormals flushed).
module fp_alu
    import fp_calc_pkg::*;
#(
    parameter int LATENCY = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [2:0]  op,
    input  logic        mode,
    output logic        valid,
    output logic [31:0] result
);
    function automatic logic [31:0] widen(input logic [31:0] x, input logic m);
        return m ? x : (x[14:10] == 5'd0) ? {x[15], 31'b0} : {x[15], {3'b0, x[14:10]} + 8'd112, x[9:0], 13'b0};
    endfunction

    logic [31:0] a_q, b_q, xa, xb, res;
    logic [2:0] op_q;
    logic mode_q, busy, sb, sr, swap, zero, inf;
    logic [5:0] cnt;
    logic [23:0] ma, mb, hi_m, lo_m;
    logic [24:0] sum;
    logic [47:0] p;
    logic signed [10:0] e, e_h;
    logic [22:0] m;

    always_ff @(posedge clk) begin
        if (reset) begin
            {a_q, b_q, op_q, mode_q, busy, valid, cnt, result} <= '0;
        end else begin
            valid <= 1'b0;
            if (start) begin
                {a_q, b_q, op_q, mode_q} <= {op_a, op_b, op, mode};
                busy <= 1'b1;
                cnt  <= '0;
            end else if (busy) begin
                cnt <= cnt + 6'd1;
                if (cnt == 6'(LATENCY - 1)) begin
                    busy   <= 1'b0;
                    valid  <= 1'b1;
                    result <= res;
                end
            end
        end
    end

    always_comb begin
        xa   = widen(a_q, mode_q);
        xb   = widen(b_q, mode_q);
        ma   = {|xa[30:23], xa[22:0]};
        mb   = {|xb[30:23], xb[22:0]};
        sb   = xb[31] ^ (op_q == OP_SUB);
        swap = xb[30:0] > xa[30:0];
        hi_m = swap ? mb : ma;
        lo_m = (swap ? ma : mb) >> (swap ? xb[30:23] - xa[30:23] : xa[30:23] - xb[30:23]);
        sum  = (xa[31] == sb) ? {1'b0, hi_m} + {1'b0, lo_m} : {1'b0, hi_m} - {1'b0, lo_m};
        sr   = (op_q == OP_ADD || op_q == OP_SUB) ? (swap ? sb : xa[31]) : xa[31] ^ xb[31];
        p    = '0;
        e    = '0;
        zero = 1'b0;
        inf  = 1'b0;
        // p carries the mantissa with its leading one expected at bit 46
        case (op_q)
            OP_ADD, OP_SUB: begin
                p = {sum, 23'b0};
                e = $signed({3'b0, swap ? xb[30:23] : xa[30:23]});
            end
            OP_MUL: begin
                p    = {24'b0, ma} * {24'b0, mb};
                e    = $signed({3'b0, xa[30:23]}) + $signed({3'b0, xb[30:23]}) - 11'sd127;
                zero = !ma[23] || !mb[23];
            end
            OP_DIV: begin
                p    = mb[23] ? ({ma, 24'b0} / {24'b0, mb}) << 22 : '0;
                e    = $signed({3'b0, xa[30:23]}) - $signed({3'b0, xb[30:23]}) + 11'sd127;
                zero = !ma[23];
                inf  = !mb[23];
            end
            default: zero = 1'b1;
        endcase
        for (int i = 0; i < 47; i++)
            if (p[47:46] == 2'b00 && p != '0) begin
                p = p << 1;
                e = e - 11'sd1;
            end
        m    = p[47] ? p[46:24] : p[45:23];
        e    = p[47] ? e + 11'sd1 : e;
        zero = zero || (p == '0 && !inf) || e <= 11'sd0;
        inf  = !zero && (inf || e >= 11'sd255);
        e_h  = e - 11'sd112;
        res  = mode_q ? (zero ? {sr, 31'b0} : inf ? {sr, 8'hFF, 23'b0} : {sr, e[7:0], m})
                      : (zero || e_h <= 11'sd0) ? {16'b0, sr, 15'b0}
                      : (inf || e_h >= 11'sd31) ? {16'b0, sr, 5'h1F, 10'b0}
                      : {16'b0, sr, e_h[4:0], m[22:13]};
    end
endmodule

// File: rtl/seg7_mux.sv
// seg7_mux: time-multiplexes four character codes onto the active-low 7-segment display.
module seg7_mux
    import fp_calc_pkg::*;
#(
    parameter int REFRESH_BITS = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d3,
    input  logic [4:0] d2,
    input  logic [4:0] d1,
    input  logic [4:0] d0,
    output logic [6:0] seg,
    output logic [3:0] an
);
    logic [REFRESH_BITS-1:0] cnt;
    logic [1:0] sel;
    logic [4:0] code;

    always_ff @(posedge clk) cnt <= reset ? '0 : cnt + 1'b1;

    assign sel  = cnt[REFRESH_BITS-1 -: 2];
    assign code = sel == 2'd3 ? d3 : sel == 2'd2 ? d2 : sel == 2'd1 ? d1 : d0;
    assign an   = ~(4'b0001 << sel);

    // seg = {g,f,e,d,c,b,a}, a lit segment is 0
    always_comb begin
        case (code)
            5'h00:   seg = 7'b1000000;
            5'h01:   seg = 7'b1111001;
            5'h02:   seg = 7'b0100100;
            5'h03:   seg = 7'b0110000;
            5'h04:   seg = 7'b0011001;
            5'h05:   seg = 7'b0010010;
            5'h06:   seg = 7'b0000010;
            5'h07:   seg = 7'b1111000;
            5'h08:   seg = 7'b0000000;
            5'h09:   seg = 7'b0010000;
            5'h0A:   seg = 7'b0001000;
            5'h0B:   seg = 7'b0000011;
            5'h0C:   seg = 7'b1000110;
            5'h0D:   seg = 7'b0100001;
            5'h0E:   seg = 7'b0000110;
            5'h0F:   seg = 7'b0001110;
            CHAR_n:  seg = 7'b0101011;
            CHAR_r:  seg = 7'b0101111;
            CHAR_L:  seg = 7'b1000111;
            CHAR_H:  seg = 7'b0001001;
            CHAR_I:  seg = 7'b1001111;
            default: seg = 7'b1111111;
        endcase
    end
endmodule

// File: rtl/basys3_fp_calc_top.sv
// basys3_fp_calc_top: button-driven operand entry, FP ALU run and result display for the Basys 3.
module basys3_fp_calc_top
    import fp_calc_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int REFRESH_BITS = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btnC,
    input  logic        btnU,
    input  logic        btnD,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic [6:0]  seg,
    output logic [3:0]  an
);
    state_t state, state_n;
    logic [SYNC_STAGES-1:0] sync_c, sync_u, sync_d;
    logic prev_c, prev_u, prev_d, edge_c, edge_u, edge_d;
    logic [31:0] a, b, result, alu_result;
    logic [3:0] conf, cfg;
    logic alu_start, alu_valid, show_result;
    logic [15:0] half;
    logic [4:0] display_d3, display_d2, display_d1, display_d0;

    always_ff @(posedge clk) begin
        if (reset) begin
            {sync_c, sync_u, sync_d, prev_c, prev_u, prev_d} <= '0;
        end else begin
            sync_c <= {sync_c[SYNC_STAGES-2:0], btnC};
            sync_u <= {sync_u[SYNC_STAGES-2:0], btnU};
            sync_d <= {sync_d[SYNC_STAGES-2:0], btnD};
            {prev_c, prev_u, prev_d} <= {sync_c[SYNC_STAGES-1], sync_u[SYNC_STAGES-1], sync_d[SYNC_STAGES-1]};
        end
    end

    assign edge_c = sync_c[SYNC_STAGES-1] & ~prev_c;
    assign edge_u = sync_u[SYNC_STAGES-1] & ~prev_u;
    assign edge_d = sync_d[SYNC_STAGES-1] & ~prev_d;

    always_ff @(posedge clk) state <= reset ? OFF : state_n;

    always_comb begin
        state_n = state;
        if (edge_u)
            state_n = OFF;
        else if (edge_d && state inside {LDAH, LDAL, LDBH, LDBL, CONF})
            state_n = IDLE;
        else
            case (state)
                OFF, IDLE: state_n = edge_c ? LDAH : state;
                LDAH:      state_n = edge_c ? LDAL : state;
                LDAL:      state_n = edge_c ? LDBH : state;
                LDBH:      state_n = edge_c ? LDBL : state;
                LDBL:      state_n = edge_c ? CONF : state;
                CONF:      state_n = edge_c ? COMPUTE : state;
                COMPUTE:   state_n = alu_valid ? RESULT : state;
                RESULT:    state_n = edge_c ? IDLE : state;
                default:   state_n = OFF;
            endcase
    end

    assign alu_start = state == CONF && state_n == COMPUTE;

    always_ff @(posedge clk) begin
        if (reset || edge_u) begin
            {a, b, conf, result} <= '0;
        end else begin
            if (edge_c && !edge_d)
                case (state)
                    LDAH:    a[31:16] <= sw;
                    LDAL:    a[15:0]  <= sw;
                    LDBH:    b[31:16] <= sw;
                    LDBL:    b[15:0]  <= sw;
                    CONF:    conf     <= sw[3:0];
                    default: ;
                endcase
            if (state == COMPUTE && alu_valid)
                result <= alu_result;
        end
    end

    // conf only lands on the start edge, so the ALU takes the switches directly then
    assign cfg = state == CONF ? sw[3:0] : conf;

    fp_alu u_alu (
        .clk    (clk),
        .reset  (reset),
        .start  (alu_start),
        .op_a   (a),
        .op_b   (b),
        .op     (cfg[2:0]),
        .mode   (cfg[3]),
        .valid  (alu_valid),
        .result (alu_result)
    );

    assign show_result = state == RESULT;
    assign half        = sw[15] ? result[31:16] : result[15:0];
    assign led         = show_result ? half : 16'h0000;

    always_comb begin
        case (state)
            OFF:     {display_d3, display_d2, display_d1, display_d0} = {CHAR_0, CHAR_F, CHAR_F, BLANK};
            LDAH:    {display_d3, display_d2, display_d1, display_d0} = {CHAR_L, CHAR_D, CHAR_A, CHAR_H};
            LDAL:    {display_d3, display_d2, display_d1, display_d0} = {CHAR_L, CHAR_D, CHAR_A, CHAR_L};
            LDBH:    {display_d3, display_d2, display_d1, display_d0} = {CHAR_L, CHAR_D, CHAR_B, CHAR_H};
            LDBL:    {display_d3, display_d2, display_d1, display_d0} = {CHAR_L, CHAR_D, CHAR_B, CHAR_L};
            CONF:    {display_d3, display_d2, display_d1, display_d0} = {CHAR_C, CHAR_0, CHAR_n, CHAR_F};
            RESULT:  {display_d3, display_d2, display_d1, display_d0} = {1'b0, half[15:12], 1'b0, half[11:8], 1'b0, half[7:4], 1'b0, half[3:0]};
            default: {display_d3, display_d2, display_d1, display_d0} = {BLANK, BLANK, BLANK, BLANK};
        endcase
    end

    seg7_mux #(.REFRESH_BITS(REFRESH_BITS)) u_mux (
        .clk   (clk),
        .reset (reset),
        .d3    (display_d3),
        .d2    (display_d2),
        .d1    (display_d1),
        .d0    (display_d0),
        .seg   (seg),
        .an    (an)
    );
endmodule

// File: tb/tb_basys3_fp_calc_top.sv
// tb_basys3_fp_calc_top: scoreboard bench; expected display/led snapshots are queued, a monitor checks each change.
module tb_basys3_fp_calc_top;
    logic clk = 1'b0, reset = 1'b1, btnC = 1'b0, btnU = 1'b0, btnD = 1'b0;
    logic [15:0] sw = 16'h0000;
    logic [15:0] led;
    logic [6:0] seg;
    logic [3:0] an;
    int n_cmp = 0, n_bad = 0;
    logic mon_en = 1'b0;
    logic [36:0] exp_q[$];
    logic [36:0] last = '1;

    always #5 clk = ~clk;

    basys3_fp_calc_top #(.SYNC_STAGES(2), .REFRESH_BITS(6)) dut (
        .clk(clk), .reset(reset), .btnC(btnC), .btnU(btnU), .btnD(btnD),
        .sw(sw), .led(led), .seg(seg), .an(an)
    );

    function automatic logic [36:0] tup(input logic [4:0] c3, c2, c1, c0, input logic [15:0] l, input logic s);
        return {c3, c2, c1, c0, l, s};
    endfunction

    function automatic logic [6:0] segs(input logic [4:0] c);
        case (c)
            5'h00: return 7'b1000000;
            5'h04: return 7'b0011001;
            5'h0A: return 7'b0001000;
            5'h0C: return 7'b1000110;
            5'h0F: return 7'b0001110;
            5'h10: return 7'b0101011;
            default: return 7'b1111111;
        endcase
    endfunction

    wire [36:0] cur = {dut.display_d3, dut.display_d2, dut.display_d1, dut.display_d0, led, dut.show_result};

    always @(negedge clk) begin
        if (mon_en && cur != last) begin
            last = cur;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL display: unexpected change to %h, nothing queued", cur);
            end else begin
                logic [36:0] want;
                want = exp_q.pop_front();
                if (cur !== want) begin
                    n_bad++;
                    $display("FAIL display: got %h want %h", cur, want);
                end
            end
        end
    end

    task automatic press(input int which, input int hold);
        @(posedge clk); #1;
        if (which == 0) btnC = 1'b1; else if (which == 1) btnU = 1'b1; else btnD = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        {btnC, btnU, btnD} = 3'b000;
        repeat (8) @(posedge clk);
    endtask

    task automatic check_digits(input logic [4:0] c3, c2, c1, c0);
        logic [4:0] codes [4];
        codes = '{c0, c1, c2, c3};
        for (int k = 3; k >= 0; k--) begin
            int t = 0;
            while (an !== ~(4'b0001 << k) && t < 300) begin
                @(negedge clk);
                t++;
            end
            n_cmp++;
            if (an !== ~(4'b0001 << k)) begin
                n_bad++;
                $display("FAIL anode%0d: got %b want %b", k, an, ~(4'b0001 << k));
            end else if (seg !== segs(codes[k])) begin
                n_bad++;
                $display("FAIL seg digit%0d: got %b want %b", k, seg, segs(codes[k]));
            end
            @(negedge clk);
        end
    endtask

    localparam logic [36:0] T_OFF  = 37'({5'h00, 5'h0F, 5'h0F, 5'h14, 16'h0, 1'b0});
    localparam logic [36:0] T_LDAH = 37'({5'h12, 5'h0D, 5'h0A, 5'h13, 16'h0, 1'b0});
    localparam logic [36:0] T_LDAL = 37'({5'h12, 5'h0D, 5'h0A, 5'h12, 16'h0, 1'b0});
    localparam logic [36:0] T_LDBH = 37'({5'h12, 5'h0D, 5'h0B, 5'h13, 16'h0, 1'b0});
    localparam logic [36:0] T_LDBL = 37'({5'h12, 5'h0D, 5'h0B, 5'h12, 16'h0, 1'b0});
    localparam logic [36:0] T_CONF = 37'({5'h0C, 5'h00, 5'h10, 5'h0F, 16'h0, 1'b0});
    localparam logic [36:0] T_BLNK = 37'({5'h14, 5'h14, 5'h14, 5'h14, 16'h0, 1'b0});

    task automatic load_all(input logic [15:0] ah, al, bh, bl);
        sw = ah; exp_q.push_back(T_LDAL); press(0, 3);
        sw = al; exp_q.push_back(T_LDBH); press(0, 3);
        sw = bh; exp_q.push_back(T_LDBL); press(0, 3);
        sw = bl; exp_q.push_back(T_CONF); press(0, 3);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        exp_q.push_back(T_OFF);
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        check_digits(5'h00, 5'h0F, 5'h0F, 5'h14);

        exp_q.push_back(T_LDAH); press(0, 3);
        exp_q.push_back(T_OFF);  press(1, 3);
        exp_q.push_back(T_LDAH); press(0, 3);
        load_all(16'h4000, 16'h0000, 16'h4040, 16'h0000);
        check_digits(5'h0C, 5'h00, 5'h10, 5'h0F);

        sw = 16'h0008;
        exp_q.push_back(T_BLNK);
        exp_q.push_back(tup(5'h00, 5'h00, 5'h00, 5'h00, 16'h0000, 1'b1));
        press(0, 3);
        begin
            int t = 0;
            while (dut.show_result !== 1'b1 && t < 500) begin
                @(negedge clk);
                t++;
            end
            n_cmp++;
            if (dut.show_result !== 1'b1) begin
                n_bad++;
                $display("FAIL result timeout: show_result %b want 1", dut.show_result);
            end
        end
        repeat (4) @(posedge clk);
        exp_q.push_back(tup(5'h04, 5'h00, 5'h0A, 5'h00, 16'h40A0, 1'b1));
        #1 sw = 16'h8008;
        repeat (4) @(posedge clk);
        check_digits(5'h04, 5'h00, 5'h0A, 5'h00);

        exp_q.push_back(T_BLNK); press(0, 3);
        exp_q.push_back(T_LDAH); press(0, 3);

        sw = 16'h1234; exp_q.push_back(T_LDAL); press(0, 3);
        exp_q.push_back(T_LDBH); press(0, 3);
        exp_q.push_back(T_LDBL); press(0, 3);
        exp_q.push_back(T_BLNK); press(2, 3);
        exp_q.push_back(T_LDAH); press(0, 3);
        load_all(16'h4000, 16'h0000, 16'h4040, 16'h0000);
        sw = 16'h0008;
        exp_q.push_back(T_BLNK); press(0, 3);
        exp_q.push_back(T_OFF);  press(1, 2);
        repeat (80) @(posedge clk);
        n_cmp++;
        if (dut.show_result !== 1'b0 || led !== 16'h0) begin
            n_bad++;
            $display("FAIL abort: show_result %b led %h want 0 0000", dut.show_result, led);
        end
        check_digits(5'h00, 5'h0F, 5'h0F, 5'h14);

        exp_q.push_back(T_LDAH); press(0, 3);
        exp_q.push_back(T_LDAL); press(0, 1000);
        repeat (50) @(posedge clk);

        while (exp_q.size() != 0) begin
            logic [36:0] w;
            w = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL display: never saw %h, final %h", w, cur);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/basys3_fp_calc_top.md
Name: basys3_fp_calc_top

Overview:
- Board-level top for a Basys 3 floating-point calculator.
- Steps the user through loading two 32-bit operands 16 bits at a time from the switches, then selecting an operation.
- Runs the floating-point ALU core and shows the 32-bit result half at a time: hex on the 4-digit 7-segment display, binary on the LEDs.
- Buttons are the only sequencing input.

Parameters:
- SYNC_STAGES, 2: button synchronizer depth (flip-flops).
- REFRESH_BITS, 17: width of the display-multiplex counter; its top 2 bits select the active digit.

Ports:
- clk, input, 1: system clock, 100 MHz.
- reset, input, 1: reset, synchronous, active-high; clock clk.
- btnC, input, 1: confirm/advance button, asynchronous, active-high.
- btnU, input, 1: user clear button; same effect as reset, acting through the synchronizer.
- btnD, input, 1: abort button.
- sw, input, 16: operand halves; sw[3:0] config; sw[15] result-half select.
- led, output, 16: result half in binary; 0 in every other state.
- seg, output, 7: segments a..g, active-low.
- an, output, 4: digit anodes, active-low.

Behaviour:
- Button handling: each button passes through a SYNC_STAGES synchronizer, then a rising-edge detector. One action per press regardless of hold length. Action completes within 4 clk of the press.
- Internal 5-bit digit codes, named exactly display_d3..display_d0 (d3 leftmost); the bench probes them hierarchically.
  - 0x00-0x0F: hex 0-F (0x00 also renders "O"; 0x0D renders "d").
  - 0x10 n, 0x11 r, 0x12 L, 0x13 H, 0x14 blank, 0x15 I.
- Internal signal show_result: 1 exactly while in state RESULT; the bench probes it.
- States, with display d3..d0 and led value:
  - OFF: 00,0F,0F,14 ("OFF "); led 0. Reset state, also entered on a btnU edge. Clears A, B, conf, result. btnC -> LDAH.
  - LDAH: 12,0D,0A,13 ("LdAH"). btnC: A[31:16] <= sw -> LDAL.
  - LDAL: "LdAL". btnC: A[15:0] <= sw -> LDBH.
  - LDBH: "LdBH". btnC: B[31:16] <= sw -> LDBL.
  - LDBL: "LdBL". btnC: B[15:0] <= sw -> CONF.
  - CONF: 0C,00,10,0F ("COnF"). btnC: conf <= sw[3:0], pulse alu_start for 1 clk -> COMPUTE.
  - COMPUTE: all blank, led 0. Wait for alu_valid, then latch result -> RESULT. btnC is ignored.
  - RESULT: sw[15]=0 shows result[15:0]; sw[15]=1 shows result[31:16]. Digits are the 4 nibbles of the selected half; led = that half. Combinational in sw[15]; valid by the next clk edge. btnC -> IDLE.
  - IDLE: all blank, led 0. btnC -> LDAH.
- led is 0 in every state except RESULT.
- Config encoding: conf[3]=1 selects single precision (32-bit), 0 selects half precision (low 16 bits of operands). conf[2:0]: 000 add, 001 sub, 010 mul, 011 div; others are handled by the core.
- btnD edge: from LDAH..CONF -> IDLE; operand registers are kept. Ignored in COMPUTE and RESULT.
- Precedence: reset > btnU > btnD > btnC when edges coincide. reset or btnU mid-COMPUTE abandons the calculation -> OFF.
- Any stray alu_valid outside COMPUTE is ignored.
- Display driver: a free-running REFRESH_BITS counter selects digit 3..0. an is a one-hot-low select; seg is decoded from the selected code. Blank and undefined codes give all segments off.
- Reset values: state OFF, A=B=result=0, conf=0, led=0, counters 0.

Decomposition:
- Shared package fp_calc_pkg holds:
  - state enum;
  - character code constants (CHAR_L, CHAR_D, CHAR_A/B/C/F, CHAR_n, CHAR_H, BLANK, ...);
  - opcode constants.
- Sub-module seg7_mux takes 4 codes plus clk/reset and produces seg and an.
- The existing fp_alu core is instantiated, with ports: clk, reset, start, op_a[31:0], op_b[31:0], op[2:0], mode, valid, result[31:0].
- Button synchronizer/edge detector stays inline.

Test Plan:
- Reset / btnU: press btnU -> display 00,0F,0F,14, led 0. Then btnC -> 12,0D,0A,13, led 0.
- Operand load: A=0x40000000 as sw=0x4000 + btnC, then sw=0x0000 + btnC -> "LdBH". Load B=0x40400000 the same way -> "COnF" (0C,00,10,0F), led 0.
- Add single precision: sw[3:0]=4'b1000, btnC -> blank during COMPUTE, then show_result=1.
  - sw[15]=0 -> digits 00,00,00,00, led 0x0000.
  - sw[15]=1 -> digits 04,00,0A,00, led 0x40A0.
- Return path: btnC in RESULT -> all digits 14, led 0. btnC again -> "LdAH".
- Abort: btnD in LDBL -> IDLE. Then btnU during COMPUTE -> OFF display, no result shown.
- Long press: hold btnC 1000 clk in LDAH -> exactly one advance, to LDAL only.
